sma_fb_param: RTL

//  Parametrised simple-moving-average filter, feedback (running-sum) form: acc += x_new - x_oldest.

---
 rtl/sma_fb_param_pkg.sv | 13 +
 rtl/sma_fb_param_if.sv | 15 +
 rtl/sma_fb_delay_line.sv | 39 +++
 rtl/sma_fb_param.sv | 77 +++++++
 4 files changed

// File: rtl/sma_fb_param_pkg.sv
// Shared definitions for the running-sum moving-average filter.
// Holds the window-size limit and the accumulator width helper.
// Optional feature macro: SMA_FB_ROUND_EN (round-half-up output instead of floor).
package sma_fb_param_pkg;

    localparam int SMA_FB_MAX_LOG2_DEPTH = 6;

    // Running sum of 2**log2_depth samples of data_w bits never overflows this width
    function automatic int acc_w(input int data_w, input int log2_depth);
        return data_w + log2_depth;
    endfunction

endpackage

// File: rtl/sma_fb_param_if.sv
// Sample-stream bus of the moving-average filter: input samples with valid and
// clear, averaged output with valid and window-full status.
interface sma_fb_param_if #(
    parameter int DATA_W = 16
);
    logic                     clr;
    logic                     x_valid;
    logic signed [DATA_W-1:0] x;
    logic                     y_valid;
    logic signed [DATA_W-1:0] y;
    logic                     window_full;

    modport master (output clr, x_valid, x, input y_valid, y, window_full);
    modport slave  (input clr, x_valid, x, output y_valid, y, window_full);
endinterface

// File: rtl/sma_fb_delay_line.sv
// Circular sample buffer of 2**LOG2_DEPTH entries. The oldest sample is the
// entry about to be overwritten, so it is read combinationally at wr_ptr
// before the write lands on the same edge.
module sma_fb_delay_line
    import sma_fb_param_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     we,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] oldest
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;

    assign oldest = mem[wr_ptr];

    // Buffer and write pointer; pointer wraps naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (we) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= (DEPTH == 1) ? '0 : wr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sma_fb_param.sv
// Simple moving average in feedback form: acc += x_new - x_oldest, y = acc / DEPTH.
// Output registered one cycle after each accepted sample, with a valid pulse
// and a window-full flag. Optional macro SMA_FB_ROUND_EN selects round-half-up
// instead of floor for the divide.
module sma_fb_param
    import sma_fb_param_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LOG2_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    sma_fb_param_if.slave bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int ACC_W = acc_w(DATA_W, LOG2_DEPTH);
    localparam int CNT_W = LOG2_DEPTH + 1;

    logic                     accept;
    logic signed [DATA_W-1:0] oldest;
    logic signed [ACC_W-1:0]  old_ext, x_ext, acc, acc_n;
    logic [CNT_W-1:0]         fill_cnt, fill_n;
    logic signed [DATA_W-1:0] y_n;

    // clr beats a coincident sample
    assign accept = bus.x_valid & ~bus.clr;

    sma_fb_delay_line #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_dly (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.clr),
        .we     (accept),
        .din    (bus.x),
        .oldest (oldest)
    );

    // Signed assignment to the wider type sign-extends both operands
    assign old_ext = oldest;
    assign x_ext   = bus.x;
    assign acc_n   = acc - old_ext + x_ext;
    assign fill_n  = (fill_cnt == CNT_W'(DEPTH)) ? fill_cnt : fill_cnt + 1'b1;

`ifdef SMA_FB_ROUND_EN
    // Half-LSB bias; evaluates to zero for a 1-deep window
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'((1 << LOG2_DEPTH) >> 1);
    logic signed [ACC_W:0] acc_rnd;
    assign acc_rnd = acc_n + HALF;
    assign y_n     = DATA_W'(acc_rnd >>> LOG2_DEPTH);
`else
    assign y_n     = DATA_W'(acc_n >>> LOG2_DEPTH);
`endif

    // Running sum, fill count and registered outputs; y holds across gaps and clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc             <= '0;
            fill_cnt        <= '0;
            bus.y           <= '0;
            bus.y_valid     <= 1'b0;
            bus.window_full <= 1'b0;
        end else if (bus.clr) begin
            acc             <= '0;
            fill_cnt        <= '0;
            bus.y_valid     <= 1'b0;
            bus.window_full <= 1'b0;
        end else begin
            bus.y_valid <= accept;
            if (accept) begin
                acc             <= acc_n;
                fill_cnt        <= fill_n;
                bus.y           <= y_n;
                bus.window_full <= (fill_n == CNT_W'(DEPTH));
            end
        end
    end

endmodule
